// File: rtl/wb_write_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Holds the architectural register geometry and the per-cycle grant encoding.
package wb_write_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_ALU  = 2'd1,
    GRANT_LL   = 2'd2
  } grant_e;

  // x0 never appears in the busy mask, so its one-hot is all zeros.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] mask;
    mask = '0;
    if (rd != ZERO_REG) begin
      mask[rd] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_ll_fifo.sv
// Small circular FIFO holding long-latency results (rd + data) until the port is free.
// Full/empty come from the registered count, so a freshly pushed entry is never visible the same cycle.
module wb_ll_fifo #(
  parameter int LL_DEPTH = 4,
  parameter int WIDTH    = 37
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  import wb_write_arbiter_pkg::*;

  localparam int PTR_W = (LL_DEPTH > 1) ? $clog2(LL_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [LL_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign o_full  = (count_q == CNT_W'(LL_DEPTH));
  assign o_empty = (count_q == '0);
  assign o_rdata = mem_q[rd_ptr_q];

  assign push_ok = i_en && i_push && !o_full;
  assign pop_ok  = i_en && i_pop && !o_empty;

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write port: merges the ALU writeback stream with buffered long-latency
// results, tracks outstanding long-latency destinations and requests ALU bubbles on starvation.
module wb_write_arbiter #(
  parameter int LL_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int XLEN         = 32
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic                                        i_clk_enable,
  input  logic                                        i_alu_valid,
  input  logic [wb_write_arbiter_pkg::REG_ADDR_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]                             i_alu_data,
  input  logic                                        i_ll_valid,
  output logic                                        o_ll_ready,
  input  logic [wb_write_arbiter_pkg::REG_ADDR_W-1:0] i_ll_rd,
  input  logic [XLEN-1:0]                             i_ll_data,
  input  logic                                        i_issue_valid,
  input  logic [wb_write_arbiter_pkg::REG_ADDR_W-1:0] i_issue_rd,
  output logic [wb_write_arbiter_pkg::NUM_REGS-1:0]   o_busy_mask,
  output logic                                        o_stall_req,
  output logic                                        o_reg_write,
  output logic [wb_write_arbiter_pkg::REG_ADDR_W-1:0] o_wr_addr,
  output logic [XLEN-1:0]                             o_wr_data
);
  import wb_write_arbiter_pkg::*;

  localparam int ENTRY_W = REG_ADDR_W + XLEN;
  localparam int CNT_W   = $clog2(STARVE_LIMIT + 1);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  grant_e                grant;

  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]       wr_data_q, wr_data_d;
  logic [CNT_W-1:0]      starve_q, starve_d;
  logic                  stall_q, stall_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  assign o_ll_ready  = !fifo_full;
  assign fifo_push   = i_ll_valid && !fifo_full;
  assign fifo_pop    = (grant == GRANT_LL);
  assign head_rd     = fifo_head[ENTRY_W-1:XLEN];
  assign head_data   = fifo_head[XLEN-1:0];

  assign o_reg_write = reg_write_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_stall_req = stall_q;
  assign o_busy_mask = busy_q;

  wb_ll_fifo #(
    .LL_DEPTH (LL_DEPTH),
    .WIDTH    (ENTRY_W)
  ) u_ll_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (i_clk_enable),
    .i_push  (fifo_push),
    .i_wdata ({i_ll_rd, i_ll_data}),
    .i_pop   (fifo_pop),
    .o_rdata (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // The ALU cannot be stalled in its own cycle, so it always takes priority.
  always_comb begin
    grant = GRANT_NONE;
    if (i_alu_valid) begin
      grant = GRANT_ALU;
    end else if (!fifo_empty) begin
      grant = GRANT_LL;
    end
  end

  always_comb begin
    reg_write_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    case (grant)
      GRANT_ALU: begin
        reg_write_d = (i_alu_rd != ZERO_REG);
        wr_addr_d   = i_alu_rd;
        wr_data_d   = i_alu_data;
      end
      GRANT_LL: begin
        reg_write_d = (head_rd != ZERO_REG);
        wr_addr_d   = head_rd;
        wr_data_d   = head_data;
      end
      default: begin
        reg_write_d = 1'b0;
      end
    endcase
  end

  // Starvation only accrues while buffered work sits behind a winning ALU.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || (grant == GRANT_LL)) begin
      starve_d = '0;
    end else if ((grant == GRANT_ALU) && (starve_q != CNT_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + CNT_W'(1);
    end
    stall_d = (starve_d == CNT_W'(STARVE_LIMIT));
  end

  // A new issue to the same rd as a draining entry must leave the bit set.
  always_comb begin
    busy_d = busy_q;
    if (grant == GRANT_LL) begin
      busy_d = busy_d & ~reg_onehot(head_rd);
    end
    if (i_issue_valid) begin
      busy_d = busy_d | reg_onehot(i_issue_rd);
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      reg_write_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      starve_q    <= '0;
      stall_q     <= 1'b0;
      busy_q      <= '0;
    end else if (i_clk_enable) begin
      reg_write_q <= reg_write_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      starve_q    <= starve_d;
      stall_q     <= stall_d;
      busy_q      <= busy_d;
    end
  end

  // Decode must bubble the ALU slot once a stall has been requested.
  assert property (@(posedge i_clk) disable iff (i_rst)
    (i_clk_enable && stall_q) |-> !i_alu_valid);

endmodule
